// File: rtl/md_pad_responder.sv
// Six-button game pad responder: counts SELECT edges into a 3-bit phase and
// drives the active-low DB9 data lines with the button group for that phase.
module md_pad_responder #(
  parameter int TIMEOUT_CYCLES = 75000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mdsel,
  input  logic [11:0] buttons,
  input  logic        mode6,
  output logic [5:0]  joy_out,
  output logic [2:0]  phase
);

  localparam logic [16:0] IDLE_MAX = 17'(TIMEOUT_CYCLES - 1);

  logic        sel_m_q, sel_m_d;
  logic        sel_s_q, sel_s_d;
  logic        sel_prev_q, sel_prev_d;
  logic [16:0] idle_q, idle_d;
  logic [2:0]  phase_q, phase_d;
  logic [5:0]  joy_q, joy_d;
  logic        sel_edge;
  logic        timeout;

  // Active-low pad word for a given phase; bit order {pin9,pin6,pin1,pin2,pin3,pin4}.
  function automatic logic [5:0] pad_word(input logic [2:0] ph, input logic [11:0] b,
                                          input logic six, input logic sel);
    logic m, s, z, y, x, c, bb, a, u, d, l, r;
    logic [5:0] w;
    {m, s, z, y, x, c, bb, a, u, d, l, r} = b;
    if (!six) begin
      w = sel ? {~c, ~bb, ~u, ~d, ~l, ~r} : {~s, ~a, ~u, ~d, 2'b00};
    end else begin
      case (ph)
        3'd1, 3'd3: w = {~s, ~a, ~u, ~d, 2'b00};
        3'd5:       w = {~s, ~a, 4'b0000};
        3'd6:       w = {~c, ~bb, ~z, ~y, ~x, ~m};
        3'd7:       w = {~s, ~a, 4'b1111};
        default:    w = {~c, ~bb, ~u, ~d, ~l, ~r};
      endcase
    end
    return w;
  endfunction

  always_comb begin
    sel_m_d    = mdsel;
    sel_s_d    = sel_m_q;
    sel_prev_d = sel_s_q;
    sel_edge   = sel_s_q ^ sel_prev_q;
    timeout    = (idle_q == IDLE_MAX);
    idle_d     = idle_q;
    phase_d    = phase_q;
    // An edge always beats the timeout; a timeout re-aligns phase parity to SELECT.
    if (sel_edge) begin
      idle_d  = '0;
      phase_d = phase_q + 3'd1;
    end else if (timeout) begin
      phase_d = {2'b00, ~sel_s_q};
    end else begin
      idle_d  = idle_q + 17'd1;
    end
    // Built from the next phase so the output register lands on the same edge as phase.
    joy_d = pad_word(phase_d, buttons, mode6, sel_s_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_m_q    <= 1'b1;
      sel_s_q    <= 1'b1;
      sel_prev_q <= 1'b1;
      idle_q     <= '0;
      phase_q    <= '0;
      joy_q      <= 6'h3F;
    end else begin
      sel_m_q    <= sel_m_d;
      sel_s_q    <= sel_s_d;
      sel_prev_q <= sel_prev_d;
      idle_q     <= idle_d;
      phase_q    <= phase_d;
      joy_q      <= joy_d;
    end
  end

  assign joy_out = joy_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_md_pad_responder.sv
// Directed bench for md_pad_responder: phase walk in both pad modes, timeout,
// mode/button latency and asynchronous reset mid-sequence.
module tb_md_pad_responder;

  localparam int T       = 64;
  localparam int SPACING = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mdsel;
  logic [11:0] buttons;
  logic        mode6;
  logic [5:0]  joy_out;
  logic [2:0]  phase;

  int n_vec = 0;
  int n_bad = 0;
  logic [5:0] last_joy;

  md_pad_responder #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .mdsel(mdsel), .buttons(buttons),
    .mode6(mode6), .joy_out(joy_out), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Toggle SELECT; output must hold for 2 cycles and update on the 3rd.
  task automatic do_edge(input string tag, input logic [5:0] ej, input logic [2:0] ep);
    mdsel = ~mdsel;
    tick(2);
    chk({tag, "_hold"}, {2'b00, joy_out}, {2'b00, last_joy});
    tick(1);
    chk({tag, "_joy"}, {2'b00, joy_out}, {2'b00, ej});
    chk({tag, "_ph"}, {5'b0, phase}, {5'b0, ep});
    last_joy = ej;
    tick(SPACING);
  endtask

  logic [5:0] t_a   [8] = '{6'h2C, 6'h3F, 6'h2C, 6'h3F, 6'h20, 6'h3F, 6'h2F, 6'h3F};
  logic [5:0] t_mz  [6] = '{6'h3C, 6'h3F, 6'h3C, 6'h3F, 6'h30, 6'h36};

  initial begin
    reset_n = 1'b0; mdsel = 1'b1; buttons = 12'h000; mode6 = 1'b1;
    tick(3);
    chk("rst_joy", {2'b00, joy_out}, 8'h3F);
    chk("rst_ph", {5'b0, phase}, 8'h00);
    reset_n = 1'b1;
    tick(2 * T);
    chk("idle_joy", {2'b00, joy_out}, 8'h3F);
    chk("idle_ph", {5'b0, phase}, 8'h00);
    last_joy = 6'h3F;

    // Six-button walk with A pressed
    buttons = 12'h010;
    tick(1);
    for (int i = 0; i < 8; i++) do_edge($sformatf("a%0d", i), t_a[i], 3'((i + 1) % 8));

    // M and Z pressed, walk to phase 6
    buttons = 12'h A00;
    tick(1);
    chk("mz_p0", {2'b00, joy_out}, 8'h3F);
    for (int i = 0; i < 6; i++) do_edge($sformatf("mz%0d", i), t_mz[i], 3'(i + 1));

    // Mode switch at phase 6 takes one clock and leaves phase alone
    mode6 = 1'b0;
    tick(1);
    chk("m3_joy", {2'b00, joy_out}, 8'h3F);
    chk("m3_ph", {5'b0, phase}, 8'h06);
    mode6 = 1'b1;
    tick(1);
    chk("m6_joy", {2'b00, joy_out}, 8'h36);
    buttons = 12'h040;
    tick(1);
    chk("btn_c_p6", {2'b00, joy_out}, 8'h1F);
    last_joy = 6'h1F;
    buttons = 12'h000;
    tick(1);
    last_joy = 6'h3F;
    do_edge("fin7", 6'h3F, 3'd7);
    do_edge("fin0", 6'h3F, 3'd0);

    // Three-button mode: only the two sel-based words ever appear
    mode6 = 1'b0;
    buttons = 12'h44F;
    tick(1);
    chk("p3_start", {2'b00, joy_out}, 8'h10);
    last_joy = 6'h10;
    for (int i = 0; i < 8; i++) do_edge($sformatf("three%0d", i), 6'h10, 3'((i + 1) % 8));

    // Timeout while SELECT is low
    mode6 = 1'b1;
    buttons = 12'h000;
    tick(1);
    last_joy = 6'h3F;
    do_edge("to1", 6'h3C, 3'd1);
    do_edge("to2", 6'h3F, 3'd2);
    do_edge("to3", 6'h3C, 3'd3);
    tick(T + 4);
    chk("to_ph", {5'b0, phase}, 8'h01);
    chk("to_joy", {2'b00, joy_out}, 8'h3C);
    do_edge("to_rise", 6'h3F, 3'd2);

    // Reset at phase 6
    buttons = 12'h A00;
    tick(1);
    chk("r_p2", {2'b00, joy_out}, 8'h3F);
    do_edge("r3", 6'h3C, 3'd3);
    do_edge("r4", 6'h3F, 3'd4);
    do_edge("r5", 6'h30, 3'd5);
    do_edge("r6", 6'h36, 3'd6);
    #2;
    reset_n = 1'b0;
    #2;
    chk("rp_joy", {2'b00, joy_out}, 8'h3F);
    chk("rp_ph", {5'b0, phase}, 8'h00);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    last_joy = 6'h3F;
    do_edge("rp_first", 6'h3C, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
